fetch_unit: RTL and testbench

- Parametrised instruction-fetch stage for the MIPS single-cycle/multicycle core.
- Owns the PC register and issues requests to an external instruction memory with a request/acknowledge handshake.
- Presents each fetched instruction to decode over a valid/ready handshake.
- Computes the next PC internally for sequential, branch, J/JAL and JR flow, detects the all-zero halt word, and counts fetched instructions.

---
 rtl/fetch_unit_pkg.sv | 30 +++
 rtl/fetch_unit_next_pc.sv | 34 +++
 rtl/fetch_unit.sv | 122 ++++++++++++
 tb/tb_fetch_unit.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: redirect kinds, FSM
// encoding, default reset vector and MIPS instruction field ranges.
package fetch_unit_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

  localparam logic [1:0] REDIR_SEQ = 2'b00;
  localparam logic [1:0] REDIR_BR  = 2'b01;
  localparam logic [1:0] REDIR_J   = 2'b10;
  localparam logic [1:0] REDIR_JR  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2,
    ST_HALT = 2'd3
  } fetch_state_e;

  // Field ranges matching mips.h
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;
  localparam int TGT_HI = 25;
  localparam int TGT_LO = 0;

  // Sign-extended 16-bit immediate scaled to a byte offset.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/fetch_unit_next_pc.sv
// Combinational next-PC selection for sequential, branch, J/JAL and JR flow.
module next_pc_calc
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc_plus4,
  input  logic [TGT_HI:0]   inst_lo,
  input  logic [1:0]        redir_kind,
  input  logic [ADDR_W-1:0] jr_target,
  output logic [ADDR_W-1:0] next_pc,
  output logic              misaligned
);

  logic [ADDR_W-1:0] br_off;

  always_comb begin
    br_off     = ADDR_W'(branch_offset(inst_lo[IMM_HI:IMM_LO]));
    next_pc    = pc_plus4;
    misaligned = 1'b0;
    case (redir_kind)
      REDIR_SEQ: next_pc = pc_plus4;
      REDIR_BR:  next_pc = pc_plus4 + br_off;
      // Region bits come from pc+4; the whole 26-bit index is kept.
      REDIR_J:   next_pc = {pc_plus4[ADDR_W-1:28], inst_lo[TGT_HI:TGT_LO], 2'b00};
      REDIR_JR: begin
        next_pc    = {jr_target[ADDR_W-1:2], 2'b00};
        misaligned = |jr_target[1:0];
      end
      default:   next_pc = pc_plus4;
    endcase
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs one outstanding imem request at a
// time and hands each word to decode over valid/ready.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int unsigned ADDR_W       = 32,
  parameter logic [31:0] RESET_PC     = DEFAULT_RESET_PC,
  parameter bit          HALT_ON_ZERO = 1'b1,
  parameter int unsigned CNT_W        = 16
) (
  input  logic              clock,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_inst,
  output logic [ADDR_W-1:0] out_pc,
  output logic [ADDR_W-1:0] out_pc_plus4,
  input  logic [1:0]        redir_kind,
  input  logic [ADDR_W-1:0] jr_target,
  output logic              halted,
  output logic              addr_err,
  output logic [CNT_W-1:0]  fetch_count
);

  localparam logic [ADDR_W-1:0] RST_PC = RESET_PC[ADDR_W-1:0];

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       out_inst_q, out_inst_d;
  logic [ADDR_W-1:0] out_pc_q, out_pc_d;
  logic [ADDR_W-1:0] out_pc_plus4_q, out_pc_plus4_d;
  logic              halted_q, halted_d;
  logic              addr_err_q, addr_err_d;
  logic [CNT_W-1:0]  fetch_count_q, fetch_count_d;

  logic [ADDR_W-1:0] next_pc;
  logic              misaligned;

  next_pc_calc #(.ADDR_W(ADDR_W)) u_next_pc (
    .pc_plus4   (out_pc_plus4_q),
    .inst_lo    (out_inst_q[TGT_HI:0]),
    .redir_kind (redir_kind),
    .jr_target  (jr_target),
    .next_pc    (next_pc),
    .misaligned (misaligned)
  );

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    out_inst_d     = out_inst_q;
    out_pc_d       = out_pc_q;
    out_pc_plus4_d = out_pc_plus4_q;
    halted_d       = halted_q;
    addr_err_d     = addr_err_q;
    fetch_count_d  = fetch_count_q;
    case (state_q)
      ST_IDLE: state_d = ST_REQ;
      ST_REQ: begin
        if (imem_ack) begin
          out_inst_d     = imem_rdata;
          out_pc_d       = pc_q;
          out_pc_plus4_d = pc_q + ADDR_W'(4);
          if (HALT_ON_ZERO && (imem_rdata == 32'h0)) begin
            halted_d = 1'b1;
            state_d  = ST_HALT;
          end else begin
            state_d = ST_HOLD;
          end
        end
      end
      ST_HOLD: begin
        // redir_kind and jr_target only matter on the decode handshake.
        if (out_ready) begin
          pc_d = next_pc;
          if (misaligned) addr_err_d = 1'b1;
          if (fetch_count_q != {CNT_W{1'b1}}) fetch_count_d = fetch_count_q + CNT_W'(1);
          state_d = ST_REQ;
        end
      end
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      pc_q           <= RST_PC;
      out_inst_q     <= '0;
      out_pc_q       <= '0;
      out_pc_plus4_q <= '0;
      halted_q       <= 1'b0;
      addr_err_q     <= 1'b0;
      fetch_count_q  <= '0;
    end else begin
      state_q        <= state_d;
      pc_q           <= pc_d;
      out_inst_q     <= out_inst_d;
      out_pc_q       <= out_pc_d;
      out_pc_plus4_q <= out_pc_plus4_d;
      halted_q       <= halted_d;
      addr_err_q     <= addr_err_d;
      fetch_count_q  <= fetch_count_d;
    end
  end

  assign imem_req     = (state_q == ST_REQ);
  assign imem_addr    = {pc_q[ADDR_W-1:2], 2'b00};
  assign out_valid    = (state_q == ST_HOLD);
  assign out_inst     = out_inst_q;
  assign out_pc       = out_pc_q;
  assign out_pc_plus4 = out_pc_plus4_q;
  assign halted       = halted_q;
  assign addr_err     = addr_err_q;
  assign fetch_count  = fetch_count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a small instruction memory, expected fetch
// addresses queued as each redirect is issued and checked as decode accepts.
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int AW = 32;
  localparam int CW = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          imem_req, imem_ack, out_valid, out_ready, halted, addr_err;
  logic [AW-1:0] imem_addr, out_pc, out_pc_plus4, jr_target;
  logic [31:0]   imem_rdata, out_inst;
  logic [1:0]    redir_kind;
  logic [CW-1:0] fetch_count;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            exp_cnt = 0;
  logic          exp_aerr = 1'b0;
  logic [AW-1:0] sb[$];

  always #5 clock = ~clock;

  fetch_unit #(
    .ADDR_W(AW), .RESET_PC(32'h0040_0000), .HALT_ON_ZERO(1'b1), .CNT_W(CW)
  ) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4),
    .redir_kind(redir_kind), .jr_target(jr_target),
    .halted(halted), .addr_err(addr_err), .fetch_count(fetch_count)
  );

  function automatic logic [31:0] rd_mem(input logic [AW-1:0] a);
    case (a)
      32'h0040_0000: return 32'h2001_0001;
      32'h0040_0004: return 32'h0810_0010;  // j 0x00400040
      32'h0040_0008: return 32'h2002_0002;
      32'h0040_000C: return 32'h0000_0000;  // halt word
      32'h0040_0010: return 32'h1000_0003;  // beq +3
      32'h0040_0014: return 32'h0810_0003;  // j 0x0040000C
      32'h0040_0018: return 32'h1000_FFFE;  // beq -2
      32'h0040_0020: return 32'h03E0_0008;  // jr
      32'h0040_0040: return 32'h0810_0004;  // j 0x00400010
      default:       return 32'h2400_0001;
    endcase
  endfunction

  always_comb imem_rdata = rd_mem(imem_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Wait for out_valid, check it against the queued address, then perform the
  // handshake with the given redirect; nxt is the address that must follow.
  task automatic accept(input logic [1:0] kind, input logic [AW-1:0] jr,
                        input bit stall_ack, input logic [AW-1:0] nxt);
    logic [AW-1:0] e;
    int n;
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("out_valid_wait", out_valid, 1);
    e = sb.pop_front();
    chk("out_pc", out_pc, e);
    chk("out_inst", out_inst, rd_mem(e));
    chk("out_pc_plus4", out_pc_plus4, e + 32'd4);
    sb.push_back(nxt);
    redir_kind = kind;
    jr_target  = jr;
    out_ready  = 1'b1;
    @(negedge clock);
    out_ready  = 1'b0;
    redir_kind = REDIR_SEQ;
    jr_target  = '0;
    if (stall_ack) imem_ack = 1'b0;
    if (kind == REDIR_JR && jr[1:0] != 2'b00) exp_aerr = 1'b1;
    exp_cnt = (exp_cnt == 3) ? 3 : exp_cnt + 1;
    chk("fetch_count", fetch_count, exp_cnt);
    chk("addr_err", addr_err, exp_aerr);
    chk("next_imem_req", imem_req, 1);
    chk("next_imem_addr", imem_addr, nxt);
  endtask

  task automatic halt_check();
    @(negedge clock);
    chk("halted", halted, 1);
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("halt_out_valid", out_valid, 0);
      chk("halt_imem_req", imem_req, 0);
      chk("halt_count", fetch_count, exp_cnt);
    end
    sb.delete();
  endtask

  initial begin
    imem_ack = 1'b1; out_ready = 1'b0; redir_kind = REDIR_SEQ; jr_target = '0;

    // Run 1: reset state, latency, three sequential fetches then halt word.
    repeat (3) @(negedge clock);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_imem_req", imem_req, 0);
    chk("rst_halted", halted, 0);
    chk("rst_addr_err", addr_err, 0);
    chk("rst_count", fetch_count, 0);
    chk("rst_out_inst", out_inst, 0);
    chk("rst_out_pc", out_pc, 0);
    chk("rst_out_pc4", out_pc_plus4, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 32'h0040_0000);
    chk("first_not_valid", out_valid, 0);
    @(negedge clock);
    chk("first_valid", out_valid, 1);
    sb.push_back(32'h0040_0000);
    accept(REDIR_SEQ, '0, 1'b0, 32'h0040_0004);
    accept(REDIR_SEQ, '0, 1'b0, 32'h0040_0008);
    accept(REDIR_SEQ, '0, 1'b0, 32'h0040_000C);
    chk("count_three", fetch_count, 3);
    halt_check();

    // Run 2: jumps, branches, JR (misaligned), stalls, saturation, halt.
    reset = 1'b1; exp_cnt = 0; exp_aerr = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    sb.push_back(32'h0040_0000);
    accept(REDIR_SEQ, '0, 1'b0, 32'h0040_0004);
    accept(REDIR_J,   '0, 1'b0, 32'h0040_0040);
    accept(REDIR_J,   '0, 1'b0, 32'h0040_0010);
    accept(REDIR_BR,  '0, 1'b0, 32'h0040_0020);
    accept(REDIR_JR,  32'h0040_0022, 1'b1, 32'h0040_0020);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      chk("stall_req", imem_req, 1);
      chk("stall_addr", imem_addr, 32'h0040_0020);
      chk("stall_no_valid", out_valid, 0);
    end
    imem_ack = 1'b1;
    @(negedge clock);
    redir_kind = REDIR_J;
    for (int i = 0; i < 5; i++) begin
      chk("hold_valid", out_valid, 1);
      chk("hold_pc", out_pc, 32'h0040_0020);
      chk("hold_inst", out_inst, rd_mem(32'h0040_0020));
      chk("hold_no_req", imem_req, 0);
      chk("hold_count", fetch_count, exp_cnt);
      @(negedge clock);
    end
    accept(REDIR_JR,  32'h0040_0018, 1'b0, 32'h0040_0018);
    accept(REDIR_BR,  '0, 1'b0, 32'h0040_0014);
    accept(REDIR_J,   '0, 1'b0, 32'h0040_000C);
    chk("addr_err_sticky", addr_err, 1);
    halt_check();

    // Run 3: reset landing mid-request with an ack in the same cycle.
    reset = 1'b1; exp_cnt = 0; exp_aerr = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    sb.push_back(32'h0040_0000);
    accept(REDIR_JR, 32'h0040_0030, 1'b1, 32'h0040_0030);
    @(negedge clock);
    chk("midreq_req", imem_req, 1);
    reset = 1'b1; imem_ack = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("midreq_rst_req", imem_req, 0);
    chk("midreq_rst_valid", out_valid, 0);
    chk("midreq_rst_count", fetch_count, 0);
    chk("midreq_rst_pc", out_pc, 0);
    sb.delete(); exp_cnt = 0;
    sb.push_back(32'h0040_0000);
    @(negedge clock);
    chk("refetch_addr", imem_addr, 32'h0040_0000);
    accept(REDIR_SEQ, '0, 1'b0, 32'h0040_0004);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
